// File: rtl/modulo_counter.sv
// Modulo-N up/down counter with synchronous clear/load, registered wrap tick and
// combinational terminal flag. Optional alarm compare enabled by MODCNT_ALARM_EN.
module modulo_counter #(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             wrap_tick,
  output logic             at_terminal
`ifdef MODCNT_ALARM_EN
  ,
  input  logic [WIDTH-1:0] alarm_value,
  output logic             alarm_tick
`endif
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] step_value;
  logic [WIDTH-1:0] load_clamped;

  // Terminal compare doubles as the wrap condition for the next enabled step.
  assign at_terminal  = up_down ? (count == TERM) : (count == '0);
  assign load_clamped = (load_value > TERM) ? TERM : load_value;

  always_comb begin
    step_value = count;
    if (up_down) step_value = at_terminal ? '0 : count + 1'b1;
    else         step_value = at_terminal ? TERM : count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count     <= '0;
      wrap_tick <= 1'b0;
    end else if (load) begin
      count     <= load_clamped;
      wrap_tick <= 1'b0;
    end else if (enable) begin
      count     <= step_value;
      wrap_tick <= at_terminal;
    end else begin
      wrap_tick <= 1'b0;
    end
  end

`ifdef MODCNT_ALARM_EN
  // Out-of-range alarm values can never match a legal count; the range check keeps that explicit.
  always_ff @(posedge clk) begin
    if (rst || clear || load) alarm_tick <= 1'b0;
    else alarm_tick <= enable && (step_value == alarm_value) && (alarm_value <= TERM);
  end
`endif

endmodule

// File: tb/tb_modulo_counter.sv
// Directed self-checking bench for modulo_counter: main 60-counter plus a
// 60 -> 60 -> 24 cascade. Alarm checks are built when MODCNT_ALARM_EN is defined.
module tb_modulo_counter;
  logic       clk = 1'b0;
  logic       rst, clear, load, enable, up_down;
  logic [5:0] load_value;
  logic [5:0] count;
  logic       wrap_tick, at_terminal;

  logic       ce;
  logic [5:0] sec_cnt, min_cnt;
  logic [4:0] hr_cnt;
  logic       sec_wrap, min_wrap, hr_wrap;
  logic       sec_term, min_term, hr_term;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

`ifdef MODCNT_ALARM_EN
  logic [5:0] alarm_value;
  logic       alarm_tick;
  logic [5:0] sec_av = 6'd63, min_av = 6'd63;
  logic [4:0] hr_av = 5'd31;
  logic       sec_at, min_at, hr_at;
`endif

  modulo_counter #(.MODULUS(60), .WIDTH(6)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_down(up_down), .count(count), .wrap_tick(wrap_tick),
    .at_terminal(at_terminal)
`ifdef MODCNT_ALARM_EN
    , .alarm_value(alarm_value), .alarm_tick(alarm_tick)
`endif
  );

  modulo_counter #(.MODULUS(60), .WIDTH(6)) u_sec (
    .clk(clk), .rst(rst), .clear(1'b0), .load(1'b0), .load_value(6'd0),
    .enable(ce), .up_down(1'b1), .count(sec_cnt), .wrap_tick(sec_wrap),
    .at_terminal(sec_term)
`ifdef MODCNT_ALARM_EN
    , .alarm_value(sec_av), .alarm_tick(sec_at)
`endif
  );

  modulo_counter #(.MODULUS(60), .WIDTH(6)) u_min (
    .clk(clk), .rst(rst), .clear(1'b0), .load(1'b0), .load_value(6'd0),
    .enable(sec_wrap), .up_down(1'b1), .count(min_cnt), .wrap_tick(min_wrap),
    .at_terminal(min_term)
`ifdef MODCNT_ALARM_EN
    , .alarm_value(min_av), .alarm_tick(min_at)
`endif
  );

  modulo_counter #(.MODULUS(24), .WIDTH(5)) u_hr (
    .clk(clk), .rst(rst), .clear(1'b0), .load(1'b0), .load_value(6'd0 >> 1),
    .enable(min_wrap), .up_down(1'b1), .count(hr_cnt), .wrap_tick(hr_wrap),
    .at_terminal(hr_term)
`ifdef MODCNT_ALARM_EN
    , .alarm_value(hr_av), .alarm_tick(hr_at)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; load = 1'b0; enable = 1'b0; up_down = 1'b1;
    load_value = 6'd0; ce = 1'b0;
`ifdef MODCNT_ALARM_EN
    alarm_value = 6'd30;
`endif
    step();
    step();
    chk("reset_count", count, 0);
    chk("reset_wrap", wrap_tick, 0);
    chk("reset_term", at_terminal, 0);

    // 1: up-count 61 steps, wrap only when count returns to 0
    rst = 1'b0; enable = 1'b1; up_down = 1'b1;
    for (int i = 1; i <= 61; i++) begin
      step();
      chk("up_count", count, i % 60);
      chk("up_wrap", wrap_tick, (i == 60) ? 1 : 0);
    end

    // 2: load 5 then down-count through the zero wrap
    enable = 1'b0; load = 1'b1; load_value = 6'd5;
    step();
    chk("load5_count", count, 5);
    chk("load5_wrap", wrap_tick, 0);
    load = 1'b0; enable = 1'b1; up_down = 1'b0;
    begin
      int exp_dn[7] = '{4, 3, 2, 1, 0, 59, 58};
      for (int i = 0; i < 7; i++) begin
        step();
        chk("dn_count", count, exp_dn[i]);
        chk("dn_wrap", wrap_tick, (exp_dn[i] == 59) ? 1 : 0);
      end
    end

    // 3: clamp on oversize load, terminal flags, load beats enable
    enable = 1'b0; load = 1'b1; load_value = 6'd63; up_down = 1'b1;
    step();
    chk("clamp_count", count, 59);
    chk("term_up_59", at_terminal, 1);
    up_down = 1'b0;
    #1 chk("term_dn_59", at_terminal, 0);
    load = 1'b1; enable = 1'b1; load_value = 6'd10; up_down = 1'b1;
    step();
    chk("load_en_count", count, 10);
    chk("load_en_wrap", wrap_tick, 0);
    load_value = 6'd0; enable = 1'b0; up_down = 1'b0;
    step();
    chk("term_dn_0", at_terminal, 1);
    up_down = 1'b1;
    #1 chk("term_up_0", at_terminal, 0);

    // wrap tick is one cycle wide once enable drops
    load_value = 6'd59;
    step();
    load = 1'b0; enable = 1'b1;
    step();
    chk("wrap_once_count", count, 0);
    chk("wrap_once_tick", wrap_tick, 1);
    enable = 1'b0;
    step();
    chk("hold_count", count, 0);
    chk("hold_wrap", wrap_tick, 0);

    // 4: clear+load+enable at 59 -> clear wins; then reset mid-run
    load = 1'b1; load_value = 6'd59;
    step();
    clear = 1'b1; load = 1'b1; enable = 1'b1; load_value = 6'd20;
    step();
    chk("clr_pri_count", count, 0);
    chk("clr_pri_wrap", wrap_tick, 0);
    clear = 1'b0; load = 1'b0; enable = 1'b1; up_down = 1'b1;
    step(); step(); step();
    chk("run3_count", count, 3);
    rst = 1'b1;
    step();
    chk("rst_run_count", count, 0);
    chk("rst_run_wrap", wrap_tick, 0);

`ifdef MODCNT_ALARM_EN
    // 6: alarm at 30, none on direct load, none when alarm out of range
    rst = 1'b0; enable = 1'b1; up_down = 1'b1; alarm_value = 6'd30;
    for (int i = 1; i <= 31; i++) begin
      step();
      chk("alarm30", alarm_tick, (i == 30) ? 1 : 0);
    end
    enable = 1'b0; load = 1'b1; load_value = 6'd30;
    step();
    chk("alarm_load", alarm_tick, 0);
    load_value = 6'd0; alarm_value = 6'd60;
    step();
    load = 1'b0; enable = 1'b1;
    begin
      int hits = 0;
      for (int i = 0; i < 61; i++) begin
        step();
        if (alarm_tick) hits++;
      end
      chk("alarm_oor_hits", hits, 0);
    end
    enable = 1'b0; rst = 1'b1;
    step();
`endif

    // 5: cascade sec -> min -> hr over 3600 enabled cycles plus 2 cycles of skew
    rst = 1'b1; enable = 1'b0;
    step();
    rst = 1'b0; ce = 1'b1;
    begin
      int hr_steps = 0;
      for (int i = 0; i < 3600; i++) begin
        step();
        if (min_wrap) hr_steps++;
      end
      ce = 1'b0;
      chk("casc_sec_wrap", sec_wrap, 1);
      step();
      chk("casc_min_wrap", min_wrap, 1);
      chk("casc_hr_pre", hr_cnt, 0);
      hr_steps++;
      step();
      for (int i = 0; i < 3; i++) begin
        step();
        if (min_wrap) hr_steps++;
      end
      chk("casc_sec", sec_cnt, 0);
      chk("casc_min", min_cnt, 0);
      chk("casc_hr", hr_cnt, 1);
      chk("casc_hr_steps", hr_steps, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
